// File: rtl/bpred_pkg.sv
// Shared constants, counter encodings and saturating helpers for the
// branch-predictor update control stage.
package bpred_pkg;

  localparam int unsigned DEF_IDX_W   = 4;
  localparam int unsigned NUM_ENTRIES = 2 ** DEF_IDX_W;
  localparam int unsigned CNT_W       = 2;

  // Two-bit counter encodings
  localparam logic [CNT_W-1:0] SNT = 2'd0;
  localparam logic [CNT_W-1:0] WNT = 2'd1;
  localparam logic [CNT_W-1:0] WT  = 2'd2;
  localparam logic [CNT_W-1:0] ST  = 2'd3;

  // Outstanding-prediction queue entry at the default index width
  typedef struct packed {
    logic [DEF_IDX_W-1:0] idx;
    logic                 pred;
  } q_entry_t;

  // Saturating increment toward strongly-taken
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == ST) ? ST : CNT_W'(c + CNT_W'(1));
  endfunction

  // Saturating decrement toward strongly-not-taken
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == SNT) ? SNT : CNT_W'(c - CNT_W'(1));
  endfunction

endpackage

// File: rtl/bpred_update_ctrl_if.sv
// Lookup / resolve / counter-file bus of the predictor update stage.
// master = surrounding pipeline and counter file, slave = bpred_update_ctrl.
interface bpred_update_ctrl_if
  import bpred_pkg::*;
#(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned NUM   = 2 ** IDX_W;
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic [CNT_W*NUM-1:0] cnt_in;
  logic                 lookup_valid;
  logic [IDX_W-1:0]     lookup_idx;
  logic                 lookup_ready;
  logic                 pred_taken;
  logic                 resolve_valid;
  logic                 resolve_taken;
  logic                 flush;
  logic [CNT_W-1:0]     wr_data;
  logic [NUM-1:0]       wr_en;
  logic                 mispredict;
  logic                 resolve_err;
  logic [OCC_W-1:0]     outstanding;

  modport master (
    output cnt_in, lookup_valid, lookup_idx, resolve_valid, resolve_taken, flush,
    input  lookup_ready, pred_taken, wr_data, wr_en, mispredict, resolve_err, outstanding
  );

  modport slave (
    input  cnt_in, lookup_valid, lookup_idx, resolve_valid, resolve_taken, flush,
    output lookup_ready, pred_taken, wr_data, wr_en, mispredict, resolve_err, outstanding
  );

endinterface

// File: rtl/bpred_fifo.sv
// Synchronous FIFO with push/pop/flush and registered occupancy count.
// Push is ignored when full, pop when empty; flush empties it at the edge.
module bpred_fifo #(
  parameter int unsigned DW    = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [DW-1:0]              i_data,
  output logic [DW-1:0]              o_head_c,
  output logic                       o_full_c,
  output logic                       o_empty_c,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full_c  = (r_count == OCC_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_head_c  = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign w_push_ok = i_push && !o_full_c && !i_flush;
  assign w_pop_ok  = i_pop && !o_empty_c && !i_flush;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents beyond the valid window are don't-care
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/bpred_update_ctrl.sv
// Update control stage around the 2-bit counter file of the branch predictor:
// predicts lookups, queues in-flight predictions, and issues saturating
// counter writes on resolve with a one-cycle bypass of the pending write.
// Optional statistics counters are enabled with `define BPRED_STATS_EN.
module bpred_update_ctrl
  import bpred_pkg::*;
#(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  bpred_update_ctrl_if.slave     bus
`ifdef BPRED_STATS_EN
  ,
  output logic [15:0]            stat_resolved,
  output logic [15:0]            stat_mispred
`endif
);

  localparam int unsigned NUM   = 2 ** IDX_W;
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
  localparam int unsigned QW    = IDX_W + 1;

  logic [CNT_W-1:0] w_eff [NUM];
  logic [QW-1:0]    w_push_data;
  logic [QW-1:0]    w_head;
  logic [IDX_W-1:0] w_head_idx;
  logic             w_head_pred;
  logic [CNT_W-1:0] w_head_eff;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_full;
  logic             w_empty;
  logic [OCC_W-1:0] w_count;
  logic             w_pred;
  logic             w_push;
  logic             w_pop;
  logic             w_err;

  logic [NUM-1:0]   r_wr_en;
  logic [CNT_W-1:0] r_wr_data;
  logic             r_mispredict;
  logic             r_resolve_err;

  // Effective counters: the pending write overrides the file output
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      w_eff[i] = r_wr_en[i] ? r_wr_data : bus.cnt_in[CNT_W*i +: CNT_W];
    end
  end

  assign w_pred       = w_eff[bus.lookup_idx][CNT_W-1];
  assign w_push       = bus.lookup_valid && !w_full && !bus.flush;
  assign w_pop        = bus.resolve_valid && !w_empty && !bus.flush;
  assign w_err        = bus.resolve_valid && w_empty && !bus.flush;
  assign w_push_data  = {bus.lookup_idx, w_pred};
  assign w_head_idx   = w_head[QW-1:1];
  assign w_head_pred  = w_head[0];
  assign w_head_eff   = w_eff[w_head_idx];
  assign w_next_cnt   = bus.resolve_taken ? sat_inc(w_head_eff) : sat_dec(w_head_eff);

  bpred_fifo #(
    .DW    (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (bus.flush),
    .i_data    (w_push_data),
    .o_head_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (w_count)
  );

  // Registered write/mispredict/error pulses for the resolved branch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en       <= '0;
      r_wr_data     <= '0;
      r_mispredict  <= 1'b0;
      r_resolve_err <= 1'b0;
    end else begin
      r_wr_en       <= w_pop ? (NUM'(1) << w_head_idx) : '0;
      r_wr_data     <= w_pop ? w_next_cnt : '0;
      r_mispredict  <= w_pop && (w_head_pred != bus.resolve_taken);
      r_resolve_err <= w_err;
    end
  end

`ifdef BPRED_STATS_EN
  logic [15:0] r_stat_resolved;
  logic [15:0] r_stat_mispred;

  // Saturating counts of accepted resolves and of mispredicts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_resolved <= '0;
      r_stat_mispred  <= '0;
    end else begin
      if (w_pop && (r_stat_resolved != 16'hFFFF))
        r_stat_resolved <= r_stat_resolved + 16'd1;
      if (w_pop && (w_head_pred != bus.resolve_taken) && (r_stat_mispred != 16'hFFFF))
        r_stat_mispred <= r_stat_mispred + 16'd1;
    end
  end

  assign stat_resolved = r_stat_resolved;
  assign stat_mispred  = r_stat_mispred;
`endif

  assign bus.lookup_ready = !w_full;
  assign bus.pred_taken   = w_pred;
  assign bus.wr_en        = r_wr_en;
  assign bus.wr_data      = r_wr_data;
  assign bus.mispredict   = r_mispredict;
  assign bus.resolve_err  = r_resolve_err;
  assign bus.outstanding  = w_count;

endmodule

// File: tb/tb_bpred_update_ctrl.sv
// Directed self-checking bench for bpred_update_ctrl (default build).
module tb_bpred_update_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bpred_update_ctrl_if #(.IDX_W(4), .DEPTH(4)) bif ();

  bpred_update_ctrl #(.IDX_W(4), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.lookup_valid  = 1'b0;
    bif.lookup_idx    = '0;
    bif.resolve_valid = 1'b0;
    bif.resolve_taken = 1'b0;
    bif.flush         = 1'b0;
  endtask

  task automatic test_reset();
    bif.cnt_in = '0;
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++; if (bif.outstanding !== 3'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", bif.outstanding); end
    checks++; if (bif.wr_en !== 16'h0000) begin errors++; $display("FAIL rst_wr_en got %h exp 0000", bif.wr_en); end
    checks++; if (bif.wr_data !== 2'b00) begin errors++; $display("FAIL rst_wr_data got %b exp 00", bif.wr_data); end
    checks++; if (bif.resolve_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bif.resolve_err); end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (bif.lookup_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bif.lookup_ready); end
  endtask

  task automatic test_async_reset();
    bif.cnt_in = '0;
    bif.lookup_valid = 1'b1;
    bif.lookup_idx   = 4'd0;
    repeat (4) tick();
    bif.lookup_valid  = 1'b0;
    bif.resolve_valid = 1'b1;
    bif.resolve_taken = 1'b1;
    tick();
    idle_inputs();
    checks++; if (bif.outstanding !== 3'd3) begin errors++; $display("FAIL ar_pre_occ got %0d exp 3", bif.outstanding); end
    checks++; if (bif.wr_en !== 16'h0001) begin errors++; $display("FAIL ar_pre_wr_en got %h exp 0001", bif.wr_en); end
    checks++; if (bif.mispredict !== 1'b1) begin errors++; $display("FAIL ar_pre_mp got %b exp 1", bif.mispredict); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bif.outstanding !== 3'd0) begin errors++; $display("FAIL ar_occ got %0d exp 0", bif.outstanding); end
    checks++; if (bif.wr_en !== 16'h0000) begin errors++; $display("FAIL ar_wr_en got %h exp 0000", bif.wr_en); end
    checks++; if (bif.mispredict !== 1'b0) begin errors++; $display("FAIL ar_mp got %b exp 0", bif.mispredict); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (bif.lookup_ready !== 1'b1) begin errors++; $display("FAIL ar_ready got %b exp 1", bif.lookup_ready); end
    checks++; if (bif.outstanding !== 3'd0) begin errors++; $display("FAIL ar_post_occ got %0d exp 0", bif.outstanding); end
  endtask

  task automatic test_mispredict();
    bif.cnt_in = '0;
    bif.cnt_in[11:10] = 2'b01;
    bif.cnt_in[19:18] = 2'b10;
    bif.lookup_idx = 4'd9;
    #1;
    checks++; if (bif.pred_taken !== 1'b1) begin errors++; $display("FAIL mp_pred9 got %b exp 1", bif.pred_taken); end
    bif.lookup_valid = 1'b1;
    bif.lookup_idx   = 4'd5;
    #1;
    checks++; if (bif.pred_taken !== 1'b0) begin errors++; $display("FAIL mp_pred5 got %b exp 0", bif.pred_taken); end
    tick();
    bif.lookup_valid = 1'b0;
    checks++; if (bif.outstanding !== 3'd1) begin errors++; $display("FAIL mp_occ got %0d exp 1", bif.outstanding); end
    bif.resolve_valid = 1'b1;
    bif.resolve_taken = 1'b1;
    tick();
    idle_inputs();
    checks++; if (bif.wr_en !== 16'h0020) begin errors++; $display("FAIL mp_wr_en got %h exp 0020", bif.wr_en); end
    checks++; if (bif.wr_data !== 2'b10) begin errors++; $display("FAIL mp_wr_data got %b exp 10", bif.wr_data); end
    checks++; if (bif.mispredict !== 1'b1) begin errors++; $display("FAIL mp_flag got %b exp 1", bif.mispredict); end
    checks++; if (bif.outstanding !== 3'd0) begin errors++; $display("FAIL mp_occ_after got %0d exp 0", bif.outstanding); end
    tick();
    checks++; if (bif.wr_en !== 16'h0000) begin errors++; $display("FAIL mp_pulse_wr_en got %h exp 0000", bif.wr_en); end
    checks++; if (bif.mispredict !== 1'b0) begin errors++; $display("FAIL mp_pulse_flag got %b exp 0", bif.mispredict); end
  endtask

  task automatic test_saturate();
    bif.cnt_in = '0;
    bif.cnt_in[7:6] = 2'b11;
    bif.lookup_valid = 1'b1;
    bif.lookup_idx   = 4'd3;
    #1;
    checks++; if (bif.pred_taken !== 1'b1) begin errors++; $display("FAIL sat_pred got %b exp 1", bif.pred_taken); end
    tick(); tick();
    bif.lookup_valid  = 1'b0;
    bif.resolve_valid = 1'b1;
    bif.resolve_taken = 1'b1;
    tick();
    checks++; if (bif.wr_en !== 16'h0008) begin errors++; $display("FAIL sat_wr_en1 got %h exp 0008", bif.wr_en); end
    checks++; if (bif.wr_data !== 2'b11) begin errors++; $display("FAIL sat_wr_data1 got %b exp 11", bif.wr_data); end
    checks++; if (bif.mispredict !== 1'b0) begin errors++; $display("FAIL sat_mp1 got %b exp 0", bif.mispredict); end
    bif.resolve_taken = 1'b0;
    tick();
    idle_inputs();
    checks++; if (bif.wr_en !== 16'h0008) begin errors++; $display("FAIL sat_wr_en2 got %h exp 0008", bif.wr_en); end
    checks++; if (bif.wr_data !== 2'b10) begin errors++; $display("FAIL sat_wr_data2 got %b exp 10", bif.wr_data); end
    checks++; if (bif.mispredict !== 1'b1) begin errors++; $display("FAIL sat_mp2 got %b exp 1", bif.mispredict); end
    tick();
  endtask

  task automatic test_bypass();
    bif.cnt_in = '0;
    bif.cnt_in[13:12] = 2'b01;
    bif.lookup_valid = 1'b1;
    bif.lookup_idx   = 4'd6;
    tick(); tick();
    bif.lookup_valid  = 1'b0;
    bif.resolve_valid = 1'b1;
    bif.resolve_taken = 1'b1;
    tick();
    checks++; if (bif.wr_data !== 2'b10) begin errors++; $display("FAIL byp_wr_data1 got %b exp 10", bif.wr_data); end
    bif.lookup_idx = 4'd6;
    #1;
    checks++; if (bif.pred_taken !== 1'b1) begin errors++; $display("FAIL byp_pred got %b exp 1", bif.pred_taken); end
    tick();
    idle_inputs();
    checks++; if (bif.wr_data !== 2'b11) begin errors++; $display("FAIL byp_wr_data2 got %b exp 11", bif.wr_data); end
    checks++; if (bif.wr_en !== 16'h0040) begin errors++; $display("FAIL byp_wr_en2 got %h exp 0040", bif.wr_en); end
    checks++; if (bif.mispredict !== 1'b1) begin errors++; $display("FAIL byp_mp2 got %b exp 1", bif.mispredict); end
    tick();
  endtask

  task automatic test_full();
    bif.cnt_in = '0;
    bif.lookup_valid = 1'b1;
    bif.lookup_idx   = 4'd1;
    repeat (4) tick();
    checks++; if (bif.lookup_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bif.lookup_ready); end
    checks++; if (bif.outstanding !== 3'd4) begin errors++; $display("FAIL full_occ got %0d exp 4", bif.outstanding); end
    bif.lookup_idx    = 4'd2;
    bif.resolve_valid = 1'b1;
    bif.resolve_taken = 1'b0;
    #1;
    checks++; if (bif.lookup_ready !== 1'b0) begin errors++; $display("FAIL full_ready_pop got %b exp 0", bif.lookup_ready); end
    tick();
    bif.lookup_valid = 1'b0;
    checks++; if (bif.outstanding !== 3'd3) begin errors++; $display("FAIL full_occ_pop got %0d exp 3", bif.outstanding); end
    checks++; if (bif.wr_en !== 16'h0002) begin errors++; $display("FAIL full_wr_en got %h exp 0002", bif.wr_en); end
    checks++; if (bif.wr_data !== 2'b00) begin errors++; $display("FAIL full_wr_data got %b exp 00", bif.wr_data); end
    repeat (3) tick();
    idle_inputs();
    checks++; if (bif.outstanding !== 3'd0) begin errors++; $display("FAIL full_drain got %0d exp 0", bif.outstanding); end
    checks++; if (bif.wr_en !== 16'h0002) begin errors++; $display("FAIL full_last_wr got %h exp 0002", bif.wr_en); end
    tick();
  endtask

  task automatic test_empty_resolve();
    bif.cnt_in = '0;
    bif.resolve_valid = 1'b1;
    bif.resolve_taken = 1'b1;
    tick();
    idle_inputs();
    checks++; if (bif.resolve_err !== 1'b1) begin errors++; $display("FAIL er_err got %b exp 1", bif.resolve_err); end
    checks++; if (bif.wr_en !== 16'h0000) begin errors++; $display("FAIL er_wr_en got %h exp 0000", bif.wr_en); end
    tick();
    checks++; if (bif.resolve_err !== 1'b0) begin errors++; $display("FAIL er_pulse got %b exp 0", bif.resolve_err); end
    bif.lookup_valid  = 1'b1;
    bif.lookup_idx    = 4'd7;
    bif.resolve_valid = 1'b1;
    bif.resolve_taken = 1'b1;
    tick();
    bif.lookup_valid = 1'b0;
    checks++; if (bif.resolve_err !== 1'b1) begin errors++; $display("FAIL er_push_err got %b exp 1", bif.resolve_err); end
    checks++; if (bif.outstanding !== 3'd1) begin errors++; $display("FAIL er_push_occ got %0d exp 1", bif.outstanding); end
    checks++; if (bif.wr_en !== 16'h0000) begin errors++; $display("FAIL er_push_wr_en got %h exp 0000", bif.wr_en); end
    tick();
    idle_inputs();
    checks++; if (bif.wr_en !== 16'h0080) begin errors++; $display("FAIL er_drain_wr_en got %h exp 0080", bif.wr_en); end
    checks++; if (bif.wr_data !== 2'b01) begin errors++; $display("FAIL er_drain_wr_data got %b exp 01", bif.wr_data); end
    checks++; if (bif.resolve_err !== 1'b0) begin errors++; $display("FAIL er_drain_err got %b exp 0", bif.resolve_err); end
    tick();
  endtask

  task automatic test_flush();
    bif.cnt_in = '0;
    bif.lookup_valid = 1'b1;
    bif.lookup_idx   = 4'd2;
    repeat (3) tick();
    bif.lookup_valid  = 1'b0;
    bif.resolve_valid = 1'b1;
    bif.resolve_taken = 1'b1;
    tick();
    checks++; if (bif.outstanding !== 3'd2) begin errors++; $display("FAIL fl_pre_occ got %0d exp 2", bif.outstanding); end
    bif.flush        = 1'b1;
    bif.lookup_valid = 1'b1;
    bif.lookup_idx   = 4'd9;
    #1;
    checks++; if (bif.wr_en !== 16'h0004) begin errors++; $display("FAIL fl_pending_wr_en got %h exp 0004", bif.wr_en); end
    checks++; if (bif.wr_data !== 2'b01) begin errors++; $display("FAIL fl_pending_wr_data got %b exp 01", bif.wr_data); end
    tick();
    idle_inputs();
    checks++; if (bif.outstanding !== 3'd0) begin errors++; $display("FAIL fl_occ got %0d exp 0", bif.outstanding); end
    checks++; if (bif.resolve_err !== 1'b0) begin errors++; $display("FAIL fl_err got %b exp 0", bif.resolve_err); end
    checks++; if (bif.wr_en !== 16'h0000) begin errors++; $display("FAIL fl_no_write got %h exp 0000", bif.wr_en); end
    checks++; if (bif.lookup_ready !== 1'b1) begin errors++; $display("FAIL fl_ready got %b exp 1", bif.lookup_ready); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    test_reset();
    test_async_reset();
    test_mispredict();
    test_saturate();
    test_bypass();
    test_full();
    test_empty_resolve();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpred_update_ctrl.md
Name: bpred_update_ctrl

Overview:
Control stage wrapped around the 16-entry two-bit counter file of the dynamic branch predictor; it both consumes and feeds that file.
- Consumes: all 16 counter outputs; produces taken/not-taken predictions for incoming branch lookups.
- Buffers: up to DEPTH in-flight predictions in order until resolution.
- Feeds: computes the saturating counter update and drives the file's shared write data and one-hot per-entry enables.

Parameters:
IDX_W, 4, index width; entry count = 2**IDX_W = 16.
DEPTH, 4, outstanding-prediction queue depth; power of two, minimum 2.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
cnt_in  in  2*2**IDX_W  flattened counter-file outputs; entry i at bits [2i+1:2i].
lookup_valid  in  1  branch lookup request.
lookup_idx  in  IDX_W  counter index for the lookup.
lookup_ready  out  1  queue can accept a lookup.
pred_taken  out  1  combinational prediction for lookup_idx.
resolve_valid  in  1  oldest outstanding branch resolved this cycle.
resolve_taken  in  1  actual outcome.
flush  in  1  discard all outstanding predictions.
wr_data  out  2  new counter value, drives the file's shared input.
wr_en  out  2**IDX_W  one-hot write enables.
mispredict  out  1  pulse; the resolved branch was mispredicted.
resolve_err  out  1  pulse; resolve arrived with an empty queue.
outstanding  out  $clog2(DEPTH)+1  queue occupancy.

Behaviour:
- Reset (async assert, sync release): queue empty, outstanding=0, wr_en=0, wr_data=0, mispredict=0, resolve_err=0, write-pending flag cleared.
- Effective counter eff(i):
  - equals the registered wr_data when a write to i is pending this cycle (wr_en[i]=1);
  - otherwise equals cnt_in[i].
  - Bypass covers the one-cycle gap before the file captures the write.
- Lookup path:
  - pred_taken = eff(lookup_idx)[1], combinational.
  - lookup_ready = !full; a full queue stays not-ready even if a pop happens in the same cycle.
  - Accept on lookup_valid && lookup_ready: push {lookup_idx, pred_taken}.
- Resolve path:
  - resolve_valid with queue non-empty pops the head {idx, pred}.
  - Next counter value: taken gives min(eff(idx)+1, 3); not taken gives max(eff(idx)-1, 0). Counter encoding is 0=SNT, 1=WNT, 2=WT, 3=ST.
  - Next cycle (registered): wr_en = one-hot(idx), wr_data = next value, mispredict = (pred != resolve_taken). All are one-cycle pulses.
  - The counter file captures the write on the following edge.
  - Update latency: 2 edges from resolve to counter change. Back-to-back resolves to the same idx are correct through the bypass.
  - resolve_valid with an empty queue: no pop, no write, resolve_err pulses next cycle.
- Simultaneous push and pop: both happen and occupancy is unchanged; an empty queue plus push plus resolve still takes the empty-queue rule.
- Flush:
  - Empties the queue at the edge; a resolve in the same cycle is ignored without resolve_err; a same-cycle lookup is not accepted.
  - An already-registered pending write still completes.
- Pointers wrap modulo DEPTH; occupancy never exceeds DEPTH.

Optional Feature:
BPRED_STATS_EN:
- Defined: adds output ports stat_resolved[15:0] and stat_mispred[15:0].
  - Each is a saturating count, held at 16'hFFFF, of accepted resolves and of mispredicts.
  - Both clear on reset.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package bpred_pkg:
  - Constants: IDX_W default, NUM_ENTRIES, CNT_W=2.
  - Counter encodings SNT/WNT/WT/ST.
  - Functions sat_inc and sat_dec.
  - Queue entry typedef {idx, pred}.
- Sub-module bpred_fifo: parameterised synchronous FIFO with push/pop/flush, full/empty and count. Reused for the queue.

Test Plan:
1. Reset asserted mid-operation with 3 entries queued -> outstanding=0, wr_en=0, mispredict=0 immediately (async); lookup_ready=1 after release.
2. cnt_in entry 5 = 2'b01; lookup idx 5 -> pred_taken=0. Resolve taken -> next cycle wr_en=16'h0020, wr_data=2'b10, mispredict=1.
3. Entry 3 = 2'b11, two queued lookups to idx 3, resolves taken then not-taken on consecutive cycles -> wr_data 2'b11 (saturated) then 2'b10 via bypass; no mispredict on the first.
4. DEPTH=4: 4 lookups -> lookup_ready=0, outstanding=4. Fifth lookup together with a resolve -> not accepted, outstanding=3.
5. resolve_valid with an empty queue -> resolve_err pulses 1 cycle, wr_en stays 0.
6. Flush with 2 queued and 1 pending write -> queue empties, pending write to its entry still issues, no resolve_err.
